// File: rtl/instr_fetch_unit_pkg.sv
// Shared core types for the instruction fetch slice: widths, reset vector,
// and the {pc, instr} payload carried through the fetch buffer.
package instr_fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Force a byte address onto a 4-byte instruction boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: redirect input, instruction memory port, decode port.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;
  logic            instr_valid;
  logic            instr_ready;
  logic [ILEN-1:0] instr_data;
  logic [XLEN-1:0] instr_pc;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output instr_valid, instr_data, instr_pc,
    input  instr_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  instr_valid, instr_data, instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH-entry synchronous FIFO of {pc, instr} with flush.
// Push while full is accepted only together with a pop.
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_i,
  input  fetch_entry_t       entry_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output fetch_entry_t       head_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [CNT_W-1:0]   count_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Storage is cleared on reset so the head reads as zero while in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= entry_i;
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (do_pop) rd_q <= rd_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: credit-limited in-order requests to instruction
// memory, buffered responses to decode, redirect flush with stale-response drop.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR,
  parameter int unsigned     DEPTH    = 2
) (
  input logic              clk,
  input logic              reset,
  instr_fetch_unit_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 2;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] live_q, live_d;
  logic [CNT_W-1:0] disc_q, disc_d;

  fetch_entry_t     head;
  fetch_entry_t     push_entry;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             flush;
  logic             gnt_fire;
  logic [SUM_W-1:0] used;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .flush_i (flush),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign bus.instr_valid = ~fifo_empty & ~bus.redirect_valid;
  assign bus.instr_data  = head.instr;
  assign bus.instr_pc    = head.pc;
  assign pop             = bus.instr_valid & bus.instr_ready;

  // A slot freed by this cycle's pop is immediately reusable, keeping 1 IPC.
  assign used = SUM_W'(live_q) + SUM_W'(disc_q) + SUM_W'(fifo_cnt) - SUM_W'(pop);
  assign bus.imem_req  = ~reset & ~bus.redirect_valid & (used < SUM_W'(DEPTH));
  assign bus.imem_addr = fetch_pc_q;
  assign gnt_fire      = bus.imem_req & bus.imem_gnt;
  assign push_entry    = '{pc: resp_pc_q, instr: bus.imem_rdata};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    live_d     = live_q;
    disc_d     = disc_q;
    push       = 1'b0;
    flush      = 1'b0;
    if (bus.redirect_valid) begin
      fetch_pc_d = word_align(bus.redirect_pc);
      resp_pc_d  = word_align(bus.redirect_pc);
      flush      = 1'b1;
      live_d     = '0;
      disc_d     = disc_q + live_q + CNT_W'(gnt_fire) - CNT_W'(bus.imem_rvalid);
    end else begin
      if (gnt_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      // Stale responses drain first; they precede any live one in order.
      if (bus.imem_rvalid) begin
        if (disc_q != '0) begin
          disc_d = disc_q - CNT_W'(1);
        end else begin
          push      = 1'b1;
          resp_pc_d = resp_pc_q + XLEN'(4);
        end
      end
      live_d = live_q + CNT_W'(gnt_fire) - CNT_W'(push);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      live_q     <= '0;
      disc_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      live_q     <= live_d;
      disc_q     <= disc_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    push |-> (~fifo_full | pop));

endmodule
